// File: rtl/fpu_mul16_iterative_pkg.sv
// rtl/fpu_mul16_iterative_pkg.sv - shared FP16 types and constants for the iterative multiplier
package fpu_mul16_iterative_pkg;

  localparam int FP16_EXPW  = 5;
  localparam int FP16_FRACW = 10;
  localparam int FP16_BIAS  = 15;

  localparam logic [15:0] FP16_QNAN = 16'h7E00;

  typedef struct packed {
    logic                  sign;
    logic [FP16_EXPW-1:0]  exp;
    logic [FP16_FRACW-1:0] frac;
  } fp16_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } mulState_t;

  // Effective exponent: subnormals share the exponent of the smallest normal.
  function automatic logic [FP16_EXPW-1:0] eff_exp(input fp16_t x);
    return (x.exp == '0) ? FP16_EXPW'(1) : x.exp;
  endfunction

endpackage

// File: rtl/fpu_mul16_iterative_if.sv
// rtl/fpu_mul16_iterative_if.sv - operand/result handshake bundle of the FP16 multiplier
interface fpu_mul16_iterative_if #(
  parameter int PFW = 20
);

  logic           inValid;
  logic           inReady;
  logic [15:0]    fpuIn1;
  logic [15:0]    fpuIn2;
  logic           outValid;
  logic           outReady;
  logic           unnormSign;
  logic [1:0]     unnormInt;
  logic [PFW-1:0] unnormFrac;
  logic [4:0]     unnormExp;
  logic           sticky;
  logic           expOverflow;
  logic           expUnderflow;
  logic           isSpecial;
  logic [15:0]    specialResult;
  logic           invalid;

  // Upstream/downstream side: supplies operands and consumes the result.
  modport master (
    output inValid, fpuIn1, fpuIn2, outReady,
    input  inReady, outValid, unnormSign, unnormInt, unnormFrac, unnormExp,
    input  sticky, expOverflow, expUnderflow, isSpecial, specialResult, invalid
  );

  // Multiplier side.
  modport slave (
    input  inValid, fpuIn1, fpuIn2, outReady,
    output inReady, outValid, unnormSign, unnormInt, unnormFrac, unnormExp,
    output sticky, expOverflow, expUnderflow, isSpecial, specialResult, invalid
  );

endinterface

// File: rtl/fpu_mul16_special.sv
// rtl/fpu_mul16_special.sv - classifies FP16 operands and forms the bypass result
module fpu_mul16_special
  import fpu_mul16_iterative_pkg::*;
(
  input  fp16_t       op_a,
  input  fp16_t       op_b,
  output logic        is_special,
  output logic        invalid,
  output logic [15:0] special_result
);

  logic a_nan, a_inf, a_zero;
  logic b_nan, b_inf, b_zero;
  logic res_sign;

  // Operand classes; anything not listed here takes the iterative path.
  always_comb begin
    a_nan    = (op_a.exp == '1) && (op_a.frac != '0);
    a_inf    = (op_a.exp == '1) && (op_a.frac == '0);
    a_zero   = (op_a.exp == '0) && (op_a.frac == '0);
    b_nan    = (op_b.exp == '1) && (op_b.frac != '0);
    b_inf    = (op_b.exp == '1) && (op_b.frac == '0);
    b_zero   = (op_b.exp == '0) && (op_b.frac == '0);
    res_sign = op_a.sign ^ op_b.sign;
  end

  // Bypass result priority: NaN / inf*0 first, then infinity, then zero.
  always_comb begin
    is_special     = a_nan | a_inf | a_zero | b_nan | b_inf | b_zero;
    invalid        = 1'b0;
    special_result = 16'h0000;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      invalid        = 1'b1;
      special_result = FP16_QNAN;
    end else if (a_inf || b_inf) begin
      special_result = {res_sign, 5'h1F, 10'h000};
    end else if (a_zero || b_zero) begin
      special_result = {res_sign, 15'h0000};
    end
  end

endmodule

// File: rtl/fpu_mul16_iterative.sv
// rtl/fpu_mul16_iterative.sv - radix-2 shift-add FP16 multiplier feeding the normalizer
module fpu_mul16_iterative
  import fpu_mul16_iterative_pkg::*;
#(
  parameter int PFW  = 2 * FP16_FRACW,
  parameter int CNTW = 4
) (
  input logic                   clock,
  input logic                   reset,
  fpu_mul16_iterative_if.slave  bus
);

  localparam int ACCW = PFW + 2;
  localparam int SIGW = FP16_FRACW + 1;
  localparam logic [CNTW-1:0] LAST_ITER = CNTW'(FP16_FRACW);

  fp16_t op_a, op_b;
  assign op_a = fp16_t'(bus.fpuIn1);
  assign op_b = fp16_t'(bus.fpuIn2);

  logic        spec_is_special;
  logic        spec_invalid;
  logic [15:0] spec_result;

  fpu_mul16_special u_special (
    .op_a           (op_a),
    .op_b           (op_b),
    .is_special     (spec_is_special),
    .invalid        (spec_invalid),
    .special_result (spec_result)
  );

  mulState_t         state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic [ACCW-1:0]   mcand_q, mcand_d;
  logic [SIGW-1:0]   mplier_q, mplier_d;
  logic signed [6:0] exp_sum_q, exp_sum_d;
  logic              sign_q, sign_d;
  logic              is_special_q, is_special_d;
  logic              invalid_q, invalid_d;
  logic [15:0]       special_result_q, special_result_d;

  logic [SIGW-1:0]   sig_a, sig_b;
  logic              accept;

  always_comb begin
    sig_a  = {(op_a.exp != '0), op_a.frac};
    sig_b  = {(op_b.exp != '0), op_b.frac};
    accept = (state_q == IDLE) && bus.inValid;
  end

  // Next-state: operand capture, one shift-add step per MULT cycle, retirement.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    acc_d            = acc_q;
    mcand_d          = mcand_q;
    mplier_d         = mplier_q;
    exp_sum_d        = exp_sum_q;
    sign_d           = sign_q;
    is_special_d     = is_special_q;
    invalid_d        = invalid_q;
    special_result_d = special_result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d = op_a.sign ^ op_b.sign;
          acc_d  = '0;
          cnt_d  = '0;
          if (spec_is_special) begin
            is_special_d     = 1'b1;
            invalid_d        = spec_invalid;
            special_result_d = spec_result;
            exp_sum_d        = '0;
            state_d          = DONE;
          end else begin
            is_special_d     = 1'b0;
            invalid_d        = 1'b0;
            special_result_d = '0;
            mcand_d          = ACCW'(sig_a);
            mplier_d         = sig_b;
            exp_sum_d        = $signed({2'b00, eff_exp(op_a)})
                             + $signed({2'b00, eff_exp(op_b)})
                             - 7'sd15;
            state_d          = MULT;
          end
        end
      end
      MULT: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.outReady) begin
          is_special_d     = 1'b0;
          invalid_d        = 1'b0;
          special_result_d = '0;
          state_d          = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; an asynchronous reset drops any in-flight op.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      acc_q            <= '0;
      mcand_q          <= '0;
      mplier_q         <= '0;
      exp_sum_q        <= '0;
      sign_q           <= 1'b0;
      is_special_q     <= 1'b0;
      invalid_q        <= 1'b0;
      special_result_q <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      acc_q            <= acc_d;
      mcand_q          <= mcand_d;
      mplier_q         <= mplier_d;
      exp_sum_q        <= exp_sum_d;
      sign_q           <= sign_d;
      is_special_q     <= is_special_d;
      invalid_q        <= invalid_d;
      special_result_q <= special_result_d;
    end
  end

  // Result presentation: everything is forced to zero outside DONE.
  always_comb begin
    bus.inReady       = (state_q == IDLE);
    bus.outValid      = 1'b0;
    bus.unnormSign    = 1'b0;
    bus.unnormInt     = 2'b00;
    bus.unnormFrac    = '0;
    bus.unnormExp     = 5'd0;
    bus.sticky        = 1'b0;
    bus.expOverflow   = 1'b0;
    bus.expUnderflow  = 1'b0;
    bus.isSpecial     = 1'b0;
    bus.specialResult = 16'h0000;
    bus.invalid       = 1'b0;
    if (state_q == DONE) begin
      bus.outValid      = 1'b1;
      bus.unnormSign    = sign_q;
      bus.isSpecial     = is_special_q;
      bus.specialResult = special_result_q;
      bus.invalid       = invalid_q;
      if (!is_special_q) begin
        bus.unnormInt  = acc_q[ACCW-1:PFW];
        bus.unnormFrac = acc_q[PFW-1:0];
        if (exp_sum_q >= 7'sd31) begin
          bus.unnormExp   = 5'd31;
          bus.expOverflow = 1'b1;
        end else if (exp_sum_q <= 7'sd0) begin
          bus.unnormExp    = 5'd0;
          bus.expUnderflow = 1'b1;
        end else begin
          bus.unnormExp = exp_sum_q[4:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_mul16_iterative.sv
// tb/tb_fpu_mul16_iterative.sv - directed self-checking bench for fpu_mul16_iterative
module tb_fpu_mul16_iterative;

  logic clock = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  fpu_mul16_iterative_if bus_if ();

  fpu_mul16_iterative dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clock = ~clock;

  // {sign, int, frac, exp, ovf, unf, isSpecial, invalid, sticky}
  function automatic logic [32:0] result_word();
    return {bus_if.unnormSign, bus_if.unnormInt, bus_if.unnormFrac, bus_if.unnormExp,
            bus_if.expOverflow, bus_if.expUnderflow, bus_if.isSpecial, bus_if.invalid,
            bus_if.sticky};
  endfunction

  // Presents one operand pair and counts edges (accept edge = 1) until outValid.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int edges);
    @(negedge clock);
    bus_if.fpuIn1  = a;
    bus_if.fpuIn2  = b;
    bus_if.inValid = 1'b1;
    @(posedge clock);
    #1;
    bus_if.inValid = 1'b0;
    edges = 1;
    while (!bus_if.outValid && edges < 40) begin
      @(posedge clock);
      #1;
      edges++;
    end
  endtask

  task automatic retire();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [32:0] w;
    #1;
    w = result_word();
    compared++;
    if (bus_if.inReady !== 1'b1 || bus_if.outValid !== 1'b0 || w !== 33'h0 ||
        bus_if.specialResult !== 16'h0) begin
      mismatched++;
      $display("FAIL reset_state: inReady=%b outValid=%b word=%h special=%h, required 1 0 0 0",
               bus_if.inReady, bus_if.outValid, w, bus_if.specialResult);
    end
  endtask

  task automatic test_normal();
    logic [15:0] va [6] = '{16'h3C00, 16'h3E00, 16'hC000, 16'h7BFF, 16'h0400, 16'h0200};
    logic [15:0] vb [6] = '{16'h3C00, 16'h3E00, 16'h3C00, 16'h7BFF, 16'h0400, 16'h0200};
    logic [32:0] ve [6] = '{
      {1'b0, 2'b01, 20'h00000, 5'd15, 1'b0, 1'b0, 3'b000},
      {1'b0, 2'b10, 20'h40000, 5'd15, 1'b0, 1'b0, 3'b000},
      {1'b1, 2'b01, 20'h00000, 5'd16, 1'b0, 1'b0, 3'b000},
      {1'b0, 2'b11, 20'hFF001, 5'd31, 1'b1, 1'b0, 3'b000},
      {1'b0, 2'b01, 20'h00000, 5'd0,  1'b0, 1'b1, 3'b000},
      {1'b0, 2'b00, 20'h40000, 5'd0,  1'b0, 1'b1, 3'b000}
    };
    int edges;
    logic [32:0] w;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], edges);
      w = result_word();
      compared++;
      if (edges !== 12) begin
        mismatched++;
        $display("FAIL normal_latency[%0d]: %h*%h edges=%0d, required 12", i, va[i], vb[i], edges);
      end
      compared++;
      if (w !== ve[i]) begin
        mismatched++;
        $display("FAIL normal_result[%0d]: %h*%h got %h, required %h", i, va[i], vb[i], w, ve[i]);
      end
      retire();
      compared++;
      if (bus_if.outValid !== 1'b0 || bus_if.inReady !== 1'b1) begin
        mismatched++;
        $display("FAIL normal_retire[%0d]: outValid=%b inReady=%b, required 0 1",
                 i, bus_if.outValid, bus_if.inReady);
      end
    end
  endtask

  task automatic test_special();
    logic [15:0] va [4] = '{16'h7C00, 16'hFC00, 16'h7E01, 16'h8000};
    logic [15:0] vb [4] = '{16'h0000, 16'h3C00, 16'h3C00, 16'h3C00};
    logic [18:0] ve [4] = '{
      {1'b1, 16'h7E00, 1'b1, 1'b0},
      {1'b1, 16'hFC00, 1'b0, 1'b1},
      {1'b1, 16'h7E00, 1'b1, 1'b0},
      {1'b1, 16'h8000, 1'b0, 1'b1}
    };
    int edges;
    logic [18:0] got;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], edges);
      got = {bus_if.isSpecial, bus_if.specialResult, bus_if.invalid, bus_if.unnormSign};
      compared++;
      if (edges !== 1) begin
        mismatched++;
        $display("FAIL special_latency[%0d]: %h*%h edges=%0d, required 1", i, va[i], vb[i], edges);
      end
      compared++;
      if (got !== ve[i]) begin
        mismatched++;
        $display("FAIL special_result[%0d]: %h*%h got %h, required %h", i, va[i], vb[i], got, ve[i]);
      end
      retire();
      compared++;
      if (bus_if.inReady !== 1'b1 || bus_if.isSpecial !== 1'b0 || bus_if.invalid !== 1'b0) begin
        mismatched++;
        $display("FAIL special_clear[%0d]: inReady=%b isSpecial=%b invalid=%b, required 1 0 0",
                 i, bus_if.inReady, bus_if.isSpecial, bus_if.invalid);
      end
    end
  endtask

  task automatic test_hold();
    logic [32:0] exp_w = {1'b0, 2'b01, 20'h80000, 5'd15, 1'b0, 1'b0, 3'b000};
    int edges;
    int bad = 0;
    bus_if.outReady = 1'b0;
    run_op(16'h3C00, 16'h3E00, edges);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      if (bus_if.outValid !== 1'b1 || bus_if.inReady !== 1'b0 || result_word() !== exp_w) begin
        bad++;
      end
    end
    compared++;
    if (edges !== 12 || bad !== 0) begin
      mismatched++;
      $display("FAIL hold_stable: edges=%0d unstable_cycles=%0d word=%h, required 12 0 %h",
               edges, bad, result_word(), exp_w);
    end
    bus_if.outReady = 1'b1;
    retire();
    compared++;
    if (bus_if.outValid !== 1'b0 || bus_if.inReady !== 1'b1) begin
      mismatched++;
      $display("FAIL hold_release: outValid=%b inReady=%b, required 0 1",
               bus_if.outValid, bus_if.inReady);
    end
  endtask

  task automatic test_reset_midop();
    int edges;
    int seen_valid = 0;
    logic [32:0] w;
    @(negedge clock);
    bus_if.fpuIn1  = 16'h3C00;
    bus_if.fpuIn2  = 16'h3C00;
    bus_if.inValid = 1'b1;
    @(posedge clock);
    #1;
    bus_if.inValid = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    w = result_word();
    compared++;
    if (bus_if.inReady !== 1'b1 || bus_if.outValid !== 1'b0 || w !== 33'h0 ||
        bus_if.specialResult !== 16'h0) begin
      mismatched++;
      $display("FAIL reset_midop: inReady=%b outValid=%b word=%h special=%h, required 1 0 0 0",
               bus_if.inReady, bus_if.outValid, w, bus_if.specialResult);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clock);
      #1;
      if (bus_if.outValid === 1'b1) seen_valid++;
    end
    compared++;
    if (seen_valid !== 0) begin
      mismatched++;
      $display("FAIL reset_discard: outValid high for %0d cycles, required 0", seen_valid);
    end
    run_op(16'h4000, 16'h4000, edges);
    w = result_word();
    compared++;
    if (edges !== 12 || w !== {1'b0, 2'b01, 20'h00000, 5'd17, 1'b0, 1'b0, 3'b000}) begin
      mismatched++;
      $display("FAIL reset_recover: edges=%0d word=%h, required 12 %h", edges, w,
               {1'b0, 2'b01, 20'h00000, 5'd17, 1'b0, 1'b0, 3'b000});
    end
    retire();
  endtask

  initial begin
    reset           = 1'b1;
    bus_if.inValid  = 1'b0;
    bus_if.fpuIn1   = 16'h0000;
    bus_if.fpuIn2   = 16'h0000;
    bus_if.outReady = 1'b1;
    test_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    test_normal();
    test_special();
    test_hold();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fpu_mul16_iterative.md
Name: fpu_mul16_iterative

Overview:
- Multi-cycle FP16 significand/exponent multiplier; the stage directly upstream of the FP16 normalizer.
- Accepts two fp16_t operands over a valid/ready handshake.
- Computes the exact 22-bit significand product with a radix-2 shift-add loop, plus the biased exponent sum.
- Presents an unnormalized result in the normalizer's input format (2-bit integer, 20-bit fraction, PFW=20). Special operands bypass the loop.

Parameters:
- PFW, 20, product fraction width below the 2-bit integer field; fixed at 2*FP16_FRACW for FP16.
- CNTW, 4, iteration counter width; must satisfy 2^CNTW > FP16_FRACW+1.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- inValid  in  1  operands valid.
- inReady  out  1  block can accept operands.
- fpuIn1  in  16  fp16_t multiplicand.
- fpuIn2  in  16  fp16_t multiplier.
- outValid  out  1  result valid.
- outReady  in  1  downstream accepts result.
- unnormSign  out  1  product sign.
- unnormInt  out  2  product integer bits.
- unnormFrac  out  PFW  product fraction bits.
- unnormExp  out  5  biased, saturated exponent.
- sticky  out  1  always 0; the product is exact.
- expOverflow  out  1  exponent sum is at or above 31.
- expUnderflow  out  1  exponent sum is at or below 0.
- isSpecial  out  1  specialResult is the final answer.
- specialResult  out  16  fp16_t final result for special cases.
- invalid  out  1  inf*0 or a NaN operand.

Behaviour:
- States: IDLE, MULT, DONE.
- Reset, asynchronous and at any point including mid-MULT:
  - State goes to IDLE; counter, accumulator and all outputs are 0.
  - inReady=1, outValid=0.
  - An in-flight operation is discarded with no output.
- inReady is 1 only in IDLE. Handshake fires when inValid && inReady.
- On accept, each operand is classified as zero, subnormal, normal, inf or NaN (exp==31, frac!=0).
- Special bypass, taken if any operand is NaN, inf or zero:
  - Go directly to DONE on the next edge with isSpecial=1.
  - Any NaN, or inf*zero: specialResult=16'h7E00, invalid=1.
  - Otherwise inf: {sign, 5'h1F, 10'h0}.
  - Otherwise zero: {sign, 15'h0}.
  - sign is fpuIn1.sign ^ fpuIn2.sign.
- Normal path setup on accept, then go to MULT with counter=0:
  - Significand = {hidden, frac}, where hidden = (exp!=0).
  - Effective exponent = max(exp,1).
  - expSum is signed 7-bit: e1eff + e2eff - 15.
  - acc = 0; mcand = zero-extended sig1 (22 bits); mplier = sig2 (11 bits).
- MULT, per cycle:
  - If mplier[0], acc += mcand.
  - Then mcand <<= 1; mplier >>= 1; counter++.
  - After the 11th iteration (counter==10) go to DONE.
- Latency: accept edge, then 11 MULT cycles; outValid rises on the 12th edge after accept.
- DONE outputs:
  - outValid=1.
  - unnormInt = acc[21:20]; unnormFrac = acc[19:0].
  - If expSum >= 31: unnormExp=31, expOverflow=1.
  - If expSum <= 0: unnormExp=0, expUnderflow=1.
  - Otherwise unnormExp = expSum[4:0].
- Leave DONE to IDLE on outValid && outReady. While outReady=0, all outputs hold stable.
- No accept in the same cycle as result retirement. Minimum issue interval is 13 cycles (normal path) or 2 cycles (special).
- Flags and isSpecial are valid only while outValid=1. They clear on the transition to IDLE.
- Subnormal*subnormal products give unnormInt=00 and are left to the downstream normalizer.

Decomposition:
- Shared constants package:
  - fp16_t, FP16_EXPW, FP16_FRACW.
  - FP16_BIAS=15, FP16_QNAN=16'h7E00.
  - mulState_t enum {IDLE, MULT, DONE}.
- One sub-module: fpu_mul16_special. Purely combinational; classifies both operands and forms specialResult, isSpecial and invalid.

Test Plan:
- 0x3C00 * 0x3C00, outReady=1: outValid on the 12th edge after accept; sign 0, int 01, frac 0, exp 15, no flags.
- 0x3E00 * 0x3E00 (1.5*1.5): int 10, frac 20'h40000, exp 15. Then 0xC000 * 0x3C00: sign 1, int 01, frac 0, exp 16.
- 0x7BFF * 0x7BFF: expOverflow=1, unnormExp=31. 0x0400 * 0x0400: expUnderflow=1, unnormExp=0.
- 0x7C00 * 0x0000: isSpecial=1, specialResult=0x7E00, invalid=1, on the 1st edge after accept. Also 0xFC00 * 0x3C00 gives specialResult 0xFC00.
- Hold outReady=0 for 5 cycles in DONE: outputs stable, inReady=0. Release: retire, then inReady=1 next cycle.
- Assert reset at MULT counter=5: outValid never rises; inReady=1 and all outputs 0 immediately. A new op after reset completes correctly.
